slave_controller: RTL and testbench

SLAVE_CONTROLLER -- requirements
Module: slave_controller

---
 rtl/slave_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_slave_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/slave_controller.sv
// I2C slave bus controller: sequences address recognition, the ACK/NACK
// handshake and the RX/TX data phases. It is driven by strobes from the
// bit-level checker and steers the shifters, the FIFOs and the SDA driver.
module slave_controller (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] address_match,
   input  logic       rw_mode,
   input  logic       address_mode,
   input  logic       byte_received,
   input  logic       ack_prep,
   input  logic       check_ack,
   input  logic       ack_done,
   input  logic       SDA_sync,
   input  logic       tx_fifo_empty,
   input  logic       rx_fifo_full,
   output logic       rx_enable,
   output logic       tx_enable,
   output logic       load_data,
   output logic       tx_fifo_read,
   output logic       rx_fifo_write,
   output logic [1:0] sda_mode,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_RX_ADDR    = 4'd1,
      ST_CHECK_ADDR = 4'd2,
      ST_ACK_WAIT   = 4'd3,
      ST_ACK_DRIVE  = 4'd4,
      ST_RX_DATA    = 4'd5,
      ST_STORE      = 4'd6,
      ST_TX_LOAD    = 4'd7,
      ST_TX_BYTE    = 4'd8,
      ST_TX_ACK     = 4'd9,
      ST_TX_CHECK   = 4'd10,
      ST_IGNORE     = 4'd11
   } state_t;

   // Context of the byte currently being handled.
   typedef enum logic [1:0] {
      PH_ADDR1     = 2'd0,   // first byte of a 10-bit address
      PH_ADDR_DONE = 2'd1,   // final address byte
      PH_DATA_WR   = 2'd2,   // master writes data to us
      PH_DATA_RD   = 2'd3    // master reads data from us
   } phase_t;

   localparam logic [1:0] SDA_RELEASE = 2'b00;
   localparam logic [1:0] SDA_DRIVE0  = 2'b01;
   localparam logic [1:0] SDA_TXDATA  = 2'b11;

   state_t state_q, state_d;
   phase_t phase_q, phase_d;
   logic   rw_q, rw_d;
   logic   first_addr_byte;

   // State, phase and latched R/W registers with asynchronous reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         phase_q <= PH_ADDR_DONE;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rw_q    <= rw_d;
      end
   end

   // The byte carrying R/W: the only byte in 7-bit mode, the first one in 10-bit mode.
   always_comb begin
      first_addr_byte = (phase_q == PH_ADDR1) || !address_mode;
   end

   // Next-state logic: stop beats start, start beats every per-state transition.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      rw_d    = rw_q;
      if (stop) begin
         state_d = ST_IDLE;
      end else if (start) begin
         state_d = ST_RX_ADDR;
         phase_d = address_mode ? PH_ADDR1 : PH_ADDR_DONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RX_ADDR: begin
               if (byte_received) state_d = ST_CHECK_ADDR;
               else               state_d = ST_RX_ADDR;
            end
            ST_CHECK_ADDR: begin
               if (first_addr_byte) begin
                  rw_d    = rw_mode;
                  state_d = address_match[1] ? ST_ACK_WAIT : ST_IGNORE;
               end else begin
                  state_d = address_match[0] ? ST_ACK_WAIT : ST_IGNORE;
               end
            end
            ST_ACK_WAIT: begin
               if (ack_prep) state_d = ST_ACK_DRIVE;
               else          state_d = ST_ACK_WAIT;
            end
            ST_ACK_DRIVE: begin
               if (ack_done) begin
                  case (phase_q)
                     PH_ADDR1: begin
                        state_d = ST_RX_ADDR;
                        phase_d = PH_ADDR_DONE;
                     end
                     PH_ADDR_DONE: begin
                        if (rw_q) begin
                           state_d = ST_TX_LOAD;
                           phase_d = PH_DATA_RD;
                        end else begin
                           state_d = ST_RX_DATA;
                           phase_d = PH_DATA_WR;
                        end
                     end
                     PH_DATA_WR: begin
                        state_d = ST_RX_DATA;
                     end
                     default: begin
                        // An ACK is never driven while reading; drop off the bus.
                        state_d = ST_IGNORE;
                     end
                  endcase
               end else begin
                  state_d = ST_ACK_DRIVE;
               end
            end
            ST_RX_DATA: begin
               if (byte_received) state_d = ST_STORE;
               else               state_d = ST_RX_DATA;
            end
            ST_STORE: begin
               // A full RX FIFO means the byte is lost, so it gets NACKed.
               state_d = rx_fifo_full ? ST_IGNORE : ST_ACK_WAIT;
            end
            ST_TX_LOAD: begin
               state_d = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
               if (ack_prep) state_d = ST_TX_ACK;
               else          state_d = ST_TX_BYTE;
            end
            ST_TX_ACK: begin
               if (check_ack) state_d = SDA_sync ? ST_IGNORE : ST_TX_CHECK;
               else           state_d = ST_TX_ACK;
            end
            ST_TX_CHECK: begin
               if (ack_done) state_d = ST_TX_LOAD;
               else          state_d = ST_TX_CHECK;
            end
            ST_IGNORE: begin
               state_d = ST_IGNORE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Moore output decode from the registered state; FIFO strobes are gated by FIFO status.
   always_comb begin
      rx_enable     = 1'b0;
      tx_enable     = 1'b0;
      load_data     = 1'b0;
      tx_fifo_read  = 1'b0;
      rx_fifo_write = 1'b0;
      sda_mode      = SDA_RELEASE;
      busy          = 1'b0;
      case (state_q)
         ST_RX_ADDR: begin
            rx_enable = 1'b1;
         end
         ST_ACK_WAIT: begin
            busy = 1'b1;
         end
         ST_ACK_DRIVE: begin
            sda_mode = SDA_DRIVE0;
            busy     = 1'b1;
         end
         ST_RX_DATA: begin
            rx_enable = 1'b1;
            busy      = 1'b1;
         end
         ST_STORE: begin
            rx_fifo_write = !rx_fifo_full;
            busy          = 1'b1;
         end
         ST_TX_LOAD: begin
            // Load even from an empty FIFO: the shifter then sends the FIFO output as is.
            load_data    = 1'b1;
            tx_fifo_read = !tx_fifo_empty;
            busy         = 1'b1;
         end
         ST_TX_BYTE: begin
            tx_enable = 1'b1;
            sda_mode  = SDA_TXDATA;
            busy      = 1'b1;
         end
         ST_TX_ACK: begin
            busy = 1'b1;
         end
         ST_TX_CHECK: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_slave_controller.sv
// Randomized bench for slave_controller: drives complete bus transactions as
// strobe sequences and compares event counts and end-of-transaction outputs
// against a transaction-level reference model.
module tb_slave_controller;

   logic       clk           = 1'b0;
   logic       n_rst         = 1'b1;
   logic       start         = 1'b0;
   logic       stop          = 1'b0;
   logic [1:0] address_match = 2'b00;
   logic       rw_mode       = 1'b0;
   logic       address_mode  = 1'b0;
   logic       byte_received = 1'b0;
   logic       ack_prep      = 1'b0;
   logic       check_ack     = 1'b0;
   logic       ack_done      = 1'b0;
   logic       SDA_sync      = 1'b1;
   logic       tx_fifo_empty = 1'b0;
   logic       rx_fifo_full  = 1'b0;
   logic       rx_enable, tx_enable, load_data, tx_fifo_read, rx_fifo_write, busy;
   logic [1:0] sda_mode;

   int n_checks = 0;
   int n_pass   = 0;

   // Event counters maintained by the monitor.
   int mon_acks = 0, mon_writes = 0, mon_loads = 0, mon_reads = 0, mon_txb = 0, mon_pulse_err = 0;
   logic       prev_ack_r = 1'b0;
   logic       prev_txb_r = 1'b0;
   logic [2:0] prev_pulse_r = 3'b000;

   always #5 clk = ~clk;

   slave_controller dut (
      .clk(clk), .n_rst(n_rst), .start(start), .stop(stop),
      .address_match(address_match), .rw_mode(rw_mode), .address_mode(address_mode),
      .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
      .ack_done(ack_done), .SDA_sync(SDA_sync), .tx_fifo_empty(tx_fifo_empty),
      .rx_fifo_full(rx_fifo_full), .rx_enable(rx_enable), .tx_enable(tx_enable),
      .load_data(load_data), .tx_fifo_read(tx_fifo_read), .rx_fifo_write(rx_fifo_write),
      .sda_mode(sda_mode), .busy(busy)
   );

   // Count ACK windows, TX windows and strobe pulses on the falling edge; flag pulses wider than one cycle.
   always @(negedge clk) begin
      prev_ack_r   <= (sda_mode == 2'b01);
      prev_txb_r   <= (sda_mode == 2'b11);
      prev_pulse_r <= {rx_fifo_write, load_data, tx_fifo_read};
      if (sda_mode == 2'b01 && !prev_ack_r) mon_acks <= mon_acks + 1;
      if (sda_mode == 2'b11 && !prev_txb_r) mon_txb <= mon_txb + 1;
      if (rx_fifo_write) mon_writes <= mon_writes + 1;
      if (load_data)     mon_loads  <= mon_loads + 1;
      if (tx_fifo_read)  mon_reads  <= mon_reads + 1;
      if (|({rx_fifo_write, load_data, tx_fifo_read} & prev_pulse_r)) mon_pulse_err <= mon_pulse_err + 1;
   end

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   // One byte on the bus as the bit checker reports it, followed by its ACK bit.
   task automatic bus_byte(input logic [1:0] m, input logic rw, input logic full, input logic master_nack);
      rx_fifo_full = full;
      tick(); tick();
      byte_received = 1'b1; tick(); byte_received = 1'b0;
      address_match = m; rw_mode = rw; tick();
      address_match = 2'b00; rw_mode = 1'b0; tick();
      ack_prep = 1'b1; tick(); ack_prep = 1'b0; tick();
      SDA_sync = master_nack; check_ack = 1'b1; tick(); check_ack = 1'b0; SDA_sync = 1'b1; tick();
      ack_done = 1'b1; tick(); ack_done = 1'b0;
      tick(); tick(); tick();
   endtask

   // Full transaction: start, address byte(s), nb data bytes, then model check and stop.
   task automatic run_txn(input string tag, input bit mode10, input logic [1:0] m1, input logic [1:0] m2,
                          input bit rw, input bit rw2, input int nb, input bit [7:0] full_v,
                          input bit [7:0] nack_v, input bit empty);
      int a0, w0, l0, r0, t0;
      int ea, ew, el, er, eb, es;
      bit addr_ok, alive;
      a0 = mon_acks; w0 = mon_writes; l0 = mon_loads; r0 = mon_reads; t0 = mon_txb;
      address_mode  = mode10;
      tx_fifo_empty = empty;
      pulse_start();
      bus_byte(m1, rw, 1'b0, 1'b0);
      if (mode10) bus_byte(m2, rw2, 1'b0, 1'b0);
      for (int i = 0; i < nb; i++) begin
         bus_byte(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), full_v[i], nack_v[i]);
      end

      // Reference: what the bus transaction should produce.
      addr_ok = mode10 ? (m1[1] && m2[0]) : m1[1];
      ea = m1[1] ? 1 : 0;
      if (mode10 && m1[1] && m2[0]) ea++;
      ew = 0; el = 0; er = 0; es = 0;
      eb = addr_ok ? 1 : 0;
      alive = 1'b1;
      if (addr_ok && !rw) begin
         for (int i = 0; i < nb; i++) begin
            if (alive) begin
               if (full_v[i]) alive = 1'b0;
               else begin ew++; ea++; end
            end
         end
         eb = alive ? 1 : 0;
      end
      if (addr_ok && rw) begin
         el = 1;
         for (int i = 0; i < nb; i++) begin
            if (alive) begin
               if (nack_v[i]) alive = 1'b0;
               else el++;
            end
         end
         eb = alive ? 1 : 0;
         es = alive ? 3 : 0;
         er = empty ? 0 : el;
      end

      check_val({tag, " ack windows"}, mon_acks - a0, ea);
      check_val({tag, " rx writes"}, mon_writes - w0, ew);
      check_val({tag, " loads"}, mon_loads - l0, el);
      check_val({tag, " tx reads"}, mon_reads - r0, er);
      check_val({tag, " tx windows"}, mon_txb - t0, el);
      check_val({tag, " busy before stop"}, int'(busy), eb);
      check_val({tag, " sda before stop"}, int'(sda_mode), es);
      check_val({tag, " rx_enable before stop"}, int'(rx_enable), (addr_ok && !rw && eb == 1) ? 1 : 0);
      pulse_stop();
      tick();
      check_val({tag, " busy after stop"}, int'(busy), 0);
      check_val({tag, " sda after stop"}, int'(sda_mode), 0);
   endtask

   initial begin
      int a0, w0, l0, r0;
      // Reset state and outputs, including strobes applied during reset.
      #2 n_rst = 1'b0;
      #1;
      check_val("reset outputs", int'({rx_enable, tx_enable, load_data, tx_fifo_read, rx_fifo_write, sda_mode, busy}), 0);
      start = 1'b1; tick(); start = 1'b0;
      check_val("reset holds idle", int'({rx_enable, sda_mode, busy}), 0);
      tick();
      n_rst = 1'b1;
      tick();
      check_val("idle after reset", int'({rx_enable, tx_enable, sda_mode, busy}), 0);

      // Directed transactions.
      run_txn("w7",     1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2, 8'h00, 8'h00, 1'b0);
      run_txn("r7",     1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2, 8'h00, 8'b10, 1'b0);
      run_txn("miss7",  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1, 8'h00, 8'h00, 1'b0);
      run_txn("w7b",    1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1, 8'h00, 8'h00, 1'b0);
      run_txn("w10",    1'b1, 2'b10, 2'b01, 1'b0, 1'b1, 1, 8'h00, 8'h00, 1'b0);
      run_txn("miss10", 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1, 8'h00, 8'h00, 1'b0);
      run_txn("full",   1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 2, 8'b01, 8'h00, 1'b0);
      run_txn("rempty", 1'b1, 2'b11, 2'b01, 1'b1, 1'b0, 3, 8'h00, 8'b100, 1'b1);

      // Randomized transactions.
      for (int t = 0; t < 16; t++) begin
         logic [1:0] m1, m2;
         bit [7:0] fv, nv;
         m1 = {($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1))};
         m2 = {1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)};
         fv = '0; nv = '0;
         for (int i = 0; i < 8; i++) begin
            fv[i] = ($urandom_range(0, 4) == 0);
            nv[i] = ($urandom_range(0, 2) == 0);
         end
         run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), m1, m2, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(1, 4), fv, nv, 1'($urandom_range(0, 1)));
      end

      // Repeated start during RX_DATA goes back to address reception.
      address_mode = 1'b0;
      pulse_start();
      bus_byte(2'b10, 1'b0, 1'b0, 1'b0);
      check_val("rx_data reached", int'({rx_enable, busy}), 3);
      pulse_start();
      check_val("rstart rx_enable", int'(rx_enable), 1);
      check_val("rstart busy", int'(busy), 0);
      a0 = mon_acks;
      bus_byte(2'b10, 1'b0, 1'b0, 1'b0);
      check_val("rstart address acked", mon_acks - a0, 1);

      // Start and stop together: stop wins, so the following byte is not acknowledged.
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check_val("start+stop idle", int'({rx_enable, busy, sda_mode}), 0);
      a0 = mon_acks;
      bus_byte(2'b11, 1'b0, 1'b0, 1'b0);
      check_val("start+stop no ack", mon_acks - a0, 0);

      // Reset asserted while transmitting releases SDA at once and emits no pulses.
      tx_fifo_empty = 1'b0;
      pulse_start();
      bus_byte(2'b10, 1'b1, 1'b0, 1'b0);
      check_val("tx_byte sda", int'(sda_mode), 3);
      w0 = mon_writes; l0 = mon_loads; r0 = mon_reads;
      #2 n_rst = 1'b0;
      #1;
      check_val("reset in tx sda", int'(sda_mode), 0);
      check_val("reset in tx outputs", int'({rx_enable, tx_enable, busy}), 0);
      tick(); tick();
      n_rst = 1'b1;
      tick();
      check_val("reset in tx no pulses", (mon_writes - w0) + (mon_loads - l0) + (mon_reads - r0), 0);
      a0 = mon_acks;
      bus_byte(2'b10, 1'b0, 1'b0, 1'b0);
      check_val("idle after tx reset no ack", mon_acks - a0, 0);

      check_val("pulse widths", mon_pulse_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
